// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arb_pkg : shared types and constants for the two-port memory arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int AW_DEF = 6;
  localparam int DW_DEF = 8;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mem_arb_2p_rr_pick2.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_pick2 : combinational two-way round-robin picker with request masking
// Rev 1.0
// ----------------------------------------------------------------------------
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);

  logic [1:0] w_elig;

  always_comb begin
    w_elig      = req & ~mask;
    grant_valid = |w_elig;
    grant_idx   = P0;
    case (w_elig)
      2'b01:   grant_idx = P0;
      2'b10:   grant_idx = P1;
      // Contention goes to whichever port was not served last.
      2'b11:   grant_idx = ~last_grant;
      default: grant_idx = P0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_arb_2p.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arb_2p : two-requester req/ack arbiter and sequencer for a single-port
//              registered-read memory
// Rev 1.0
// ----------------------------------------------------------------------------
module mem_arb_2p
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic          busy
);

  state_e        state_q, state_d;
  logic          grant_q, grant_d;
  logic          last_grant_q, last_grant_d;
  logic          mem_rd_q, mem_rd_d;
  logic          mem_wr_q, mem_wr_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_din_q, mem_din_d;

  logic [1:0]    w_pick_mask;
  logic          w_grant_valid;
  logic          w_grant_idx;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;

  // In DONE the acked port's req still belongs to the finished transaction.
  always_comb begin
    w_pick_mask = 2'b00;
    if (state_q == DONE) begin
      w_pick_mask = (grant_q == P1) ? 2'b10 : 2'b01;
    end
  end

  rr_pick2 u_pick (
    .req         ({p1_req, p0_req}),
    .mask        (w_pick_mask),
    .last_grant  (last_grant_q),
    .grant_valid (w_grant_valid),
    .grant_idx   (w_grant_idx)
  );

  always_comb begin
    w_sel_we    = (w_grant_idx == P1) ? p1_we    : p0_we;
    w_sel_addr  = (w_grant_idx == P1) ? p1_addr  : p0_addr;
    w_sel_wdata = (w_grant_idx == P1) ? p1_wdata : p0_wdata;
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    mem_rd_d     = 1'b0;
    mem_wr_d     = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (w_grant_valid) begin
          state_d      = ISSUE;
          grant_d      = w_grant_idx;
          last_grant_d = w_grant_idx;
          mem_addr_d   = w_sel_addr;
          mem_din_d    = w_sel_wdata;
          mem_rd_d     = ~w_sel_we;
          mem_wr_d     = w_sel_we;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= P0;
      last_grant_q <= P1;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
    end
  end

  assign mem_rd   = mem_rd_q;
  assign mem_wr   = mem_wr_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;

  assign p0_ack   = (state_q == DONE) && (grant_q == P0);
  assign p1_ack   = (state_q == DONE) && (grant_q == P1);
  assign busy     = (state_q != IDLE);

  assign p0_rdata = mem_dout;
  assign p1_rdata = mem_dout;

endmodule
`default_nettype wire

// File: tb/tb_mem_arb_2p.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_arb_2p : scoreboard bench for mem_arb_2p with a behavioural memory
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mem_arb_2p;

  typedef struct {
    logic       we;
    logic [5:0] addr;
    logic [7:0] wdata;
    int         start;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req_v = 2'b00;
  logic [1:0] we_v = 2'b00;
  logic [5:0] addr_v [2];
  logic [7:0] wdata_v [2];

  logic       p0_ack, p1_ack;
  logic [7:0] p0_rdata, p1_rdata;
  logic       mem_rd, mem_wr, busy;
  logic [5:0] mem_addr;
  logic [7:0] mem_din;
  logic [7:0] mem_dout = 8'h00;
  logic [1:0] ack_v;

  logic [7:0] mem_arr [64];
  logic [7:0] ref_mem [64];
  exp_t       exp_q [2][$];
  int         ack_log [$];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  bit fair_pending = 1'b0;
  int fair_expect = 0;

  mem_arb_2p dut (
    .clk      (clk),
    .rst      (rst),
    .p0_req   (req_v[0]),
    .p0_we    (we_v[0]),
    .p0_addr  (addr_v[0]),
    .p0_wdata (wdata_v[0]),
    .p0_ack   (p0_ack),
    .p0_rdata (p0_rdata),
    .p1_req   (req_v[1]),
    .p1_we    (we_v[1]),
    .p1_addr  (addr_v[1]),
    .p1_wdata (wdata_v[1]),
    .p1_ack   (p1_ack),
    .p1_rdata (p1_rdata),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .busy     (busy)
  );

  assign ack_v = {p1_ack, p0_ack};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port memory: registered read, read wins over write.
  always @(posedge clk) begin
    if (mem_rd)      mem_dout <= mem_arr[mem_addr];
    else if (mem_wr) mem_arr[mem_addr] <= mem_din;
  end

  function automatic logic [7:0] init_val(input int i);
    return 8'((i * 37) + 11);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: each ack retires the oldest outstanding request of that port.
  always @(negedge clk) begin
    if (rst) begin
      fair_pending = 1'b0;
    end else begin
      if (mem_rd || mem_wr) chk("rd_wr_exclusive", 32'(mem_rd & mem_wr), 32'd0);
      if (p0_ack && p1_ack) chk("double_ack", 32'(ack_v), 32'd1);
      for (int p = 0; p < 2; p++) begin
        if (ack_v[p]) begin
          if (exp_q[p].size() == 0) begin
            chk($sformatf("unexpected_ack_p%0d", p), 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = exp_q[p].pop_front();
            n_checks++;
            if (cyc - e.start < 2) begin
              n_fail++;
              $display("FAIL ack_latency_p%0d: got %0d cycles, required at least 2", p, cyc - e.start);
            end
            if (e.we) ref_mem[e.addr] = e.wdata;
            else chk($sformatf("rdata_p%0d_a%0h", p, e.addr),
                     32'((p == 0) ? p0_rdata : p1_rdata), 32'(ref_mem[e.addr]));
            if (fair_pending) chk("rr_fairness", 32'(p), 32'(fair_expect));
            fair_expect  = 1 - p;
            fair_pending = (exp_q[1-p].size() != 0) && (exp_q[1-p][0].start <= cyc);
            ack_log.push_back(p);
          end
        end
      end
    end
  end

  task automatic start_txn(input int p, input logic we, input logic [5:0] a, input logic [7:0] d);
    exp_t e;
    req_v[p]   = 1'b1;
    we_v[p]    = we;
    addr_v[p]  = a;
    wdata_v[p] = d;
    e.we = we; e.addr = a; e.wdata = d; e.start = cyc;
    exp_q[p].push_back(e);
  endtask

  task automatic wait_ack(input int p, output int ack_cyc);
    ack_cyc = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ack_v[p]) begin
        ack_cyc = cyc;
        break;
      end
    end
    if (ack_cyc < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack_timeout_p%0d: got no ack, required one within 40 cycles", p);
    end
  endtask

  task automatic do_txn(input int p, input logic we, input logic [5:0] a, input logic [7:0] d,
                        input bit keep, output int ack_cyc);
    start_txn(p, we, a, d);
    wait_ack(p, ack_cyc);
    @(posedge clk); #1;
    if (!keep) req_v[p] = 1'b0;
  endtask

  task automatic burst(input int p, input int n, input bit hold, input bit rand_gap);
    int  ac;
    bit  keep;
    for (int i = 0; i < n; i++) begin
      keep = (i != n - 1) && (hold || ($urandom_range(0, 1) == 1));
      do_txn(p, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), 8'($urandom), keep, ac);
      if (!keep && rand_gap) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    int a0, a1, a2, base;
    addr_v[0] = '0; addr_v[1] = '0; wdata_v[0] = '0; wdata_v[1] = '0;
    for (int i = 0; i < 64; i++) begin
      mem_arr[i] = init_val(i);
      ref_mem[i] = init_val(i);
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", 32'({busy, mem_rd, mem_wr, p0_ack, p1_ack, mem_addr, mem_din}), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // p0 write 05 <= A5
    start_txn(0, 1'b1, 6'h05, 8'hA5);
    @(negedge clk);
    @(negedge clk);
    chk("t1_issue", 32'({mem_rd, mem_wr, mem_addr, mem_din}), 32'({1'b0, 1'b1, 6'h05, 8'hA5}));
    @(negedge clk);
    chk("t1_ack", 32'({p1_ack, p0_ack, mem_rd}), 32'b010);
    @(posedge clk); #1; req_v[0] = 1'b0;
    repeat (2) @(posedge clk); #1;

    // p1 read 05
    start_txn(1, 1'b0, 6'h05, 8'h00);
    @(negedge clk);
    @(negedge clk);
    chk("t2_issue", 32'({mem_rd, mem_wr, mem_addr}), 32'({1'b1, 1'b0, 6'h05}));
    @(negedge clk);
    chk("t2_ack", 32'({p1_ack, p0_ack, p1_rdata}), 32'({2'b10, 8'hA5}));
    @(posedge clk); #1; req_v[1] = 1'b0;

    // Simultaneous requests straight out of reset
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    start_txn(0, 1'b0, 6'h00, 8'h00);
    start_txn(1, 1'b0, 6'h3F, 8'h00);
    @(negedge clk);
    @(negedge clk);
    chk("t3_p0_issue", 32'({mem_rd, mem_addr}), 32'({1'b1, 6'h00}));
    @(negedge clk);
    chk("t3_p0_ack", 32'({p1_ack, p0_ack, p0_rdata}), 32'({2'b01, init_val(0)}));
    @(posedge clk); #1; req_v[0] = 1'b0;
    @(negedge clk);
    chk("t3_p1_issue", 32'({mem_rd, mem_addr}), 32'({1'b1, 6'h3F}));
    @(negedge clk);
    chk("t3_p1_ack", 32'({p1_ack, p0_ack, p1_rdata}), 32'({2'b10, init_val(63)}));
    @(posedge clk); #1; req_v[1] = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Both ports held continuously: grants alternate
    base = ack_log.size();
    fork
      burst(0, 4, 1'b1, 1'b0);
      burst(1, 4, 1'b1, 1'b0);
    join
    chk("t4_count", 32'(ack_log.size() - base), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (base + i < ack_log.size()) chk($sformatf("t4_alt_%0d", i), 32'(ack_log[base + i]), 32'(i % 2));
    end
    repeat (2) @(posedge clk); #1;

    // p0 back-to-back reads with req held: top address and wrap
    do_txn(0, 1'b0, 6'h3E, 8'h00, 1'b1, a0);
    do_txn(0, 1'b0, 6'h3F, 8'h00, 1'b1, a1);
    do_txn(0, 1'b0, 6'h00, 8'h00, 1'b0, a2);
    chk("t5_gap01", 32'(a1 - a0), 32'd3);
    chk("t5_gap12", 32'(a2 - a1), 32'd3);
    repeat (2) @(posedge clk); #1;

    // Reset during the ISSUE cycle of a p1 read
    req_v[1] = 1'b1; we_v[1] = 1'b0; addr_v[1] = 6'h10;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1; req_v[1] = 1'b0;
    @(negedge clk);
    chk("t6_issue_rd", 32'(mem_rd), 32'd1);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("t6_after_rst", 32'({busy, mem_rd, p1_ack}), 32'd0);
    @(posedge clk); #1;
    base = ack_log.size();
    fork
      begin int ac; do_txn(0, 1'b0, 6'h02, 8'h00, 1'b0, ac); end
      begin int ac; do_txn(1, 1'b1, 6'h02, 8'h3C, 1'b0, ac); end
    join
    chk("t6_first_winner", 32'((ack_log.size() > base) ? ack_log[base] : 9), 32'd0);
    repeat (2) @(posedge clk); #1;

    // Randomized traffic on a narrow address window
    fork
      burst(0, 30, 1'b0, 1'b1);
      burst(1, 30, 1'b0, 1'b1);
    join

    repeat (5) @(posedge clk);
    chk("queues_drained", 32'(exp_q[0].size() + exp_q[1].size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, required completion within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
